cic_interpolator: RTL and testbench

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

---
 rtl/cic_interpolator.sv | 138 +++++++++++++
 tb/tb_cic_interpolator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// Cascaded integrator-comb interpolator: low-rate comb section, zero-stuffing by FACTOR,
// then a pipelined high-rate integrator section. All arithmetic wraps at OUTPUT_WIDTH.
module cic_interpolator #(
  parameter int SECTIONS     = 3,
  parameter int FACTOR       = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 22
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_enable,
  input  logic signed [INPUT_WIDTH-1:0]  filter_in,
  output logic                           ce_in,
  output logic signed [OUTPUT_WIDTH-1:0] filter_out,
  output logic                           ce_out
);

  localparam logic [15:0] LAST_PHASE = 16'(FACTOR - 1);

  generate
    if (FACTOR < 2 || FACTOR > 65535) begin : g_bad_factor
      $error("cic_interpolator: FACTOR must lie in 2..65535");
    end
    if (SECTIONS < 1) begin : g_bad_sections
      $error("cic_interpolator: SECTIONS must be at least 1");
    end
    if (OUTPUT_WIDTH < INPUT_WIDTH + SECTIONS * $clog2(FACTOR)) begin : g_bad_width
      $error("cic_interpolator: OUTPUT_WIDTH too small for the CIC gain");
    end
  endgenerate

  logic [15:0]                     phase_reg;
  logic [15:0]                     phase_next;
  logic                            phase_1;
  logic signed [OUTPUT_WIDTH-1:0]  input_reg;
  logic signed [OUTPUT_WIDTH-1:0]  input_next;
  logic signed [OUTPUT_WIDTH-1:0]  comb     [0:SECTIONS];
  logic signed [OUTPUT_WIDTH-1:0]  delay_reg[1:SECTIONS];
  logic signed [OUTPUT_WIDTH-1:0]  integ_reg[1:SECTIONS];
  logic signed [OUTPUT_WIDTH-1:0]  upsampled;
  logic signed [OUTPUT_WIDTH-1:0]  output_reg;
  logic                            ce_out_reg;

  // Phase counter: counts enabled edges modulo FACTOR; frozen while clk_enable is low.
  always_comb begin
    phase_next = phase_reg;
    if (clk_enable) begin
      if (phase_reg == LAST_PHASE) begin
        phase_next = 16'd0;
      end else begin
        phase_next = phase_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg <= 16'd0;
    end else begin
      phase_reg <= phase_next;
    end
  end

  assign ce_in   = clk_enable && (phase_reg == 16'd0);
  assign phase_1 = clk_enable && (phase_reg == 16'd1);

  // Input capture, sign-extended to the internal width.
  always_comb begin
    input_next = input_reg;
    if (ce_in) begin
      input_next = {{(OUTPUT_WIDTH-INPUT_WIDTH){filter_in[INPUT_WIDTH-1]}}, filter_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      input_reg <= '0;
    end else begin
      input_reg <= input_next;
    end
  end

  assign comb[0] = input_reg;

  // Comb section runs at the low rate: its delays advance one edge after the sample lands.
  generate
    for (genvar gi = 1; gi <= SECTIONS; gi++) begin : g_comb
      assign comb[gi] = comb[gi-1] - delay_reg[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          delay_reg[gi] <= '0;
        end else if (phase_1) begin
          delay_reg[gi] <= comb[gi-1];
        end
      end
    end
  endgenerate

  // Zero-stuffing: one comb result per FACTOR enabled edges, zeros in between.
  assign upsampled = phase_1 ? comb[SECTIONS] : '0;

  generate
    for (genvar gi = 1; gi <= SECTIONS; gi++) begin : g_integ
      logic signed [OUTPUT_WIDTH-1:0] integ_in;

      if (gi == 1) begin : g_first
        assign integ_in = upsampled;
      end else begin : g_chain
        assign integ_in = integ_reg[gi-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          integ_reg[gi] <= '0;
        end else if (clk_enable) begin
          integ_reg[gi] <= integ_reg[gi] + integ_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      output_reg <= '0;
      ce_out_reg <= 1'b0;
    end else begin
      ce_out_reg <= clk_enable;
      if (clk_enable) begin
        output_reg <= integ_reg[SECTIONS];
      end
    end
  end

  assign filter_out = output_reg;
  assign ce_out     = ce_out_reg;

endmodule

// File: tb/tb_cic_interpolator.sv
// Table-driven bench for cic_interpolator: expected outputs come from a convolution model
// of the input stream with the SECTIONS-fold boxcar impulse response, queued per enabled edge.
module tb_cic_interpolator;

  localparam int N    = 3;
  localparam int R    = 4;
  localparam int IW   = 16;
  localparam int OW   = 22;
  localparam int HLEN = N * (R - 1) + 1;

  logic                 clk;
  logic                 reset;
  logic                 clk_enable;
  logic signed [IW-1:0] filter_in;
  logic                 ce_in;
  logic signed [OW-1:0] filter_out;
  logic                 ce_out;

  cic_interpolator #(
    .SECTIONS(N), .FACTOR(R), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)
  ) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .filter_in(filter_in),
    .ce_in(ce_in), .filter_out(filter_out), .ce_out(ce_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string  name;
    int     x0;        // first low-rate sample
    int     xr;        // all later samples
    int     edges;     // enabled edges to run
    int     gap_pct;   // percentage of cycles with clk_enable low
    int     reset_at;  // enabled edge at which reset hits mid-stream, -1 for none
    longint final_exp; // filter_out after the last enabled edge
    bit     imp_chk;   // compare edges 4..13 against the literal impulse response
  } vec_t;

  int     total = 0;
  int     bad   = 0;
  int     h[];
  int     xs[$];
  longint q[$];
  longint outs[64];

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    logic signed [OW-1:0] t;
    t = v[OW-1:0];
    return longint'(t);
  endfunction

  function automatic longint model_y(input int n);
    longint acc = 0;
    for (int m = 0; m < xs.size(); m++) begin
      int k = n - R - R * m;
      if (k >= 0 && k < HLEN) acc += longint'(xs[m]) * h[k];
    end
    return wrap(acc);
  endfunction

  task automatic apply_reset(input string tag);
    clk_enable = 1'b1;
    filter_in  = '0;
    reset      = 1'b1;
    #1;
    check({tag, "_rst_out"}, longint'(filter_out), 0);
    check({tag, "_rst_ceout"}, longint'(ce_out), 0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_rst_hold_out"}, longint'(filter_out), 0);
    reset = 1'b0;
    #1;
    check({tag, "_rst_cein"}, longint'(ce_in), 1);
  endtask

  task automatic run_vector(input vec_t v);
    int     n = 0;
    int     cycles = 0;
    int     cein_cnt = 0;
    int     out_idx = 0;
    bit     did_reset = 0;
    bit     en;
    int     xval;
    longint exp_v;
    longint last_out = 0;
    int     imp_ref[10];

    imp_ref = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
    q.delete();
    xs.delete();
    apply_reset(v.name);

    while (n < v.edges) begin
      if (v.reset_at >= 0 && n == v.reset_at && !did_reset) begin
        did_reset = 1;
        apply_reset({v.name, "_mid"});
        q.delete();
        xs.delete();
        n = 0;
        cein_cnt = 0;
        out_idx = 0;
      end
      en   = ($urandom_range(99) < v.gap_pct) ? 1'b0 : 1'b1;
      xval = (n / R == 0) ? v.x0 : v.xr;
      clk_enable = en;
      filter_in  = IW'(xval);
      #1;
      check({v.name, "_cein"}, longint'(ce_in), longint'(en && (n % R == 0)));
      if (ce_in) cein_cnt++;
      if (en) begin
        if (n % R == 0) xs.push_back(xval);
        q.push_back(model_y(n));
        n++;
      end
      @(negedge clk);
      check({v.name, "_ceout"}, longint'(ce_out), longint'(en));
      if (ce_out) begin
        if (q.size() == 0) begin
          check({v.name, "_unexpected_out"}, 1, 0);
        end else begin
          exp_v = q.pop_front();
          check($sformatf("%s_out_e%0d", v.name, out_idx), longint'(filter_out), exp_v);
          last_out = longint'(filter_out);
          if (out_idx < 64) outs[out_idx] = last_out;
          out_idx++;
        end
      end
      cycles++;
      if (cycles > 4000) begin
        check({v.name, "_timeout"}, cycles, 4000);
        break;
      end
    end

    check({v.name, "_cein_count"}, cein_cnt, (v.edges + R - 1) / R);
    check({v.name, "_final"}, last_out, v.final_exp);
    check({v.name, "_queue_left"}, q.size(), 0);
    if (v.imp_chk) begin
      for (int i = 0; i < 10; i++) begin
        check($sformatf("%s_imp%0d", v.name, i + 4), outs[i + 4], imp_ref[i]);
      end
    end
  endtask

  vec_t vecs[7];

  initial begin
    int cur[];
    int nxt[];

    reset = 1'b1;
    clk_enable = 1'b0;
    filter_in = '0;

    // Impulse response: N-fold convolution of R ones.
    cur = new[1];
    cur[0] = 1;
    for (int s = 0; s < N; s++) begin
      nxt = new[cur.size() + R - 1];
      foreach (nxt[i]) nxt[i] = 0;
      foreach (cur[i]) for (int j = 0; j < R; j++) nxt[i + j] += cur[i];
      cur = nxt;
    end
    h = cur;

    vecs[0] = '{"impulse",      1,      0,      16, 0,  -1, 0,       1'b1};
    vecs[1] = '{"dc1000",       1000,   1000,   16, 0,  -1, 16000,   1'b0};
    vecs[2] = '{"fs_neg",       -32768, -32768, 16, 0,  -1, -524288, 1'b0};
    vecs[3] = '{"fs_pos",       32767,  32767,  16, 0,  -1, 524272,  1'b0};
    vecs[4] = '{"step",         -32768, 32767,  24, 0,  -1, 524272,  1'b0};
    vecs[5] = '{"impulse_gaps", 1,      0,      16, 50, -1, 0,       1'b1};
    vecs[6] = '{"dc_midreset",  1000,   1000,   16, 0,  7,  16000,   1'b0};

    for (int t = 0; t < 7; t++) begin
      run_vector(vecs[t]);
      $display("vector %s: checks so far=%0d bad=%0d", vecs[t].name, total, bad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
